// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame sequencer: frame length, FSM state
// encoding, index/counter widths, bit-reversal and sample-width helpers.
// No ports; imported by fft_frame_buf and fft_seq_ctrl.
package fft_pkg;

  localparam int FRAME_LEN = 8;
  localparam int IDX_W     = 3;
  localparam int LAT_W     = 4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // 3-bit bit reversal: 0,1,2,3,4,5,6,7 -> 0,4,2,6,1,5,3,7
  function automatic logic [IDX_W-1:0] bitrev3(input logic [IDX_W-1:0] i);
    return {i[0], i[1], i[2]};
  endfunction

  // Sample width for a given N: W = 2**N
  function automatic int width(input int n);
    return 2 ** n;
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// Eight-slot sample register buffer with single-slot write or whole-frame load.
// Latency: writes visible on the flat read port the cycle after the write edge.
// Backpressure: none; the caller decides when to write.
// Ports: clk, rst (sync, active-high, clears all slots); wr_en/wr_idx/wr_data
// write one slot; ld_en/ld_frame load all slots (ld_en has priority);
// rd_frame presents slot k at bits [k*W +: W].
module fft_frame_buf
  import fft_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [W-1:0]           wr_data,
  input  logic                   ld_en,
  input  logic [FRAME_LEN*W-1:0] ld_frame,
  output logic [FRAME_LEN*W-1:0] rd_frame
);

  logic [W-1:0] mem [FRAME_LEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FRAME_LEN; i++) mem[i] <= '0;
    end else if (ld_en) begin
      for (int i = 0; i < FRAME_LEN; i++) mem[i] <= ld_frame[i*W +: W];
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  for (genvar g = 0; g < FRAME_LEN; g++) begin : g_rd
    assign rd_frame[g*W +: W] = mem[g];
  end

endmodule

// File: rtl/fft_seq_ctrl.sv
// Sequencer that collects 8 samples, issues them as one frame to an FFT
// datapath, captures the result LAT cycles later and streams it out in order.
// Backpressure: s_ready only in LOAD; output holds while m_ready is low.
// Ports: clk, rst (sync, active-high); s_valid/s_ready/s_data input stream;
// dp_start/dp_in frame issue, dp_res result frame; m_valid/m_ready/m_data/
// m_last output stream (m_last on slot 7); busy high outside LOAD.
// Build option: FFT_SEQ_CTRL_BITREV_EN stores input sample n in slot bitrev3(n).
module fft_seq_ctrl
  import fft_pkg::*;
#(
  parameter int N   = 4,
  parameter int LAT = 3,               // legal 1..15
  localparam int W  = width(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [W-1:0]           s_data,
  output logic                   dp_start,
  output logic [FRAME_LEN*W-1:0] dp_in,
  input  logic [FRAME_LEN*W-1:0] dp_res,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [W-1:0]           m_data,
  output logic                   m_last,
  output logic                   busy
);

  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LAT - 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [LAT_W-1:0]   lat, lat_nxt;
  logic               load_st, issue_st, drain_st;
  logic               in_we, cap;
  logic [IDX_W-1:0]   wr_idx;
  logic [FRAME_LEN*W-1:0] in_frame, res_frame;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      idx   <= '0;
      lat   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      lat   <= lat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    lat_nxt   = lat;
    load_st   = 1'b0;
    issue_st  = 1'b0;
    drain_st  = 1'b0;
    cap       = 1'b0;
    case (state)
      LOAD: begin
        load_st = 1'b1;
        if (s_valid) begin
          // idx wraps 7->0, so it is already cleared for DRAIN's reuse
          idx_nxt = idx + 3'd1;
          if (idx == 3'd7) state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        issue_st  = 1'b1;
        lat_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        // lat reads k-1 on the k-th cycle after dp_start, so the capture
        // lands exactly LAT cycles after the strobe
        lat_nxt = lat + 4'd1;
        if (lat == LAT_LAST) begin
          cap       = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        drain_st = 1'b1;
        if (m_ready) begin
          idx_nxt = idx + 3'd1;
          if (idx == 3'd7) state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign in_we = load_st & s_valid & ~rst;

`ifdef FFT_SEQ_CTRL_BITREV_EN
  assign wr_idx = bitrev3(idx);
`else
  assign wr_idx = idx;
`endif

  fft_frame_buf #(.W(W)) u_in_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (in_we),
    .wr_idx   (wr_idx),
    .wr_data  (s_data),
    .ld_en    (1'b0),
    .ld_frame ('0),
    .rd_frame (in_frame)
  );

  fft_frame_buf #(.W(W)) u_res_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (1'b0),
    .wr_idx   ('0),
    .wr_data  ('0),
    .ld_en    (cap & ~rst),
    .ld_frame (dp_res),
    .rd_frame (res_frame)
  );

  // Outputs are forced to idle while rst is high, including the first reset
  // cycle before the state register has been cleared.
  always_comb begin
    s_ready  = load_st & ~rst;
    dp_start = issue_st & ~rst;
    m_valid  = drain_st & ~rst;
    m_last   = drain_st & ~rst & (idx == 3'd7);
    busy     = ~load_st & ~rst;
    dp_in    = rst ? '0 : in_frame;
    m_data   = rst ? '0 : res_frame[idx*W +: W];
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
module tb_fft_seq_ctrl;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int LAT = 3;
  localparam int FW  = 8 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          dp_start;
  logic [FW-1:0] dp_in;
  logic [FW-1:0] dp_res;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int ds_cnt   = 0;

  always #5 clk = ~clk;

  fft_seq_ctrl #(.N(N), .LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .dp_start (dp_start),
    .dp_in    (dp_in),
    .dp_res   (dp_res),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .busy     (busy)
  );

  // Datapath stub: identity, valid only exactly LAT cycles after dp_start.
  logic [FW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= dp_start ? dp_in : {8{16'hDEAD}};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_res = pipe[LAT-1];

  always @(posedge clk) if (!rst && dp_start) ds_cnt <= ds_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic [W-1:0] din [8];
    logic [W-1:0] exp [8];   // natural-order output for the default build
    int           gap;       // idle cycles between input samples
    logic [3:0]   rdy;       // m_ready pattern, bit (c % 4) on c-th valid cycle
  } vec_t;

  vec_t tbl [3];

  // Output slot k holds input sample perm(k).
  function automatic int perm(input int k);
`ifdef FFT_SEQ_CTRL_BITREV_EN
    int br [8];
    br = '{0, 4, 2, 6, 1, 5, 3, 7};
    return br[k];
`else
    return k;
`endif
  endfunction

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Feeds 8 samples; returns in the cycle after the 8th handshake (ISSUE).
  task automatic load(input logic [W-1:0] d [8], input int gap);
    for (int n = 0; n < 8; n++) begin
      int b;
      b = 0;
      s_data  = d[n];
      s_valid = 1'b1;
      while (!s_ready && b < 100) begin tick; b++; end
      chk("load_ready_wait", (b < 100), 1'b1);
      tick;
      if (gap > 0 && n < 7) begin
        s_valid = 1'b0;
        s_data  = 16'hBEEF;
        repeat (gap) tick;
      end
    end
    s_valid = 1'b0;
    s_data  = 16'hBEEF;
  endtask

  task automatic drain(input logic [W-1:0] e [8], input logic [3:0] rdy);
    int n, c, budget;
    logic stalled;
    logic [W-1:0] held;
    logic held_last;
    n = 0; c = 0; budget = 0; stalled = 1'b0; held = '0; held_last = 1'b0;
    while (n < 8 && budget < 200) begin
      m_ready = rdy[c % 4];
      if (stalled) begin
        chk("stall_m_valid", m_valid, 1'b1);
        chk("stall_m_data", m_data, held);
        chk("stall_m_last", m_last, held_last);
      end
      if (m_valid) begin
        if (m_ready) begin
          chk($sformatf("m_data[%0d]", n), m_data, e[n]);
          chk($sformatf("m_last[%0d]", n), m_last, (n == 7));
          n++;
          stalled = 1'b0;
        end else begin
          stalled   = 1'b1;
          held      = m_data;
          held_last = m_last;
        end
        c++;
      end
      tick;
      budget++;
    end
    m_ready = 1'b0;
    chk("drain_count", n, 8);
    chk("after_drain_s_ready", s_ready, 1'b1);
    chk("after_drain_m_valid", m_valid, 1'b0);
    chk("after_drain_busy", busy, 1'b0);
  endtask

  initial begin
    logic [W-1:0]  e [8];
    logic [FW-1:0] ef;
    int d0, b;

    tbl[0].din = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    tbl[0].exp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    tbl[0].gap = 0;
    tbl[0].rdy = 4'b1111;
    tbl[1].din = '{16'h0000, 16'hFFFF, 16'h8001, 16'h7FFE, 16'hA5A5, 16'h5A5A, 16'h00FF, 16'hFF00};
    tbl[1].exp = '{16'h0000, 16'hFFFF, 16'h8001, 16'h7FFE, 16'hA5A5, 16'h5A5A, 16'h00FF, 16'hFF00};
    tbl[1].gap = 0;
    tbl[1].rdy = 4'b1001;
    tbl[2].din = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
    tbl[2].exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
    tbl[2].gap = 2;
    tbl[2].rdy = 4'b0101;

    // Reset with traffic present on the inputs
    rst = 1'b1; s_valid = 1'b1; s_data = 16'h1234; m_ready = 1'b1;
    repeat (3) tick;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_dp_start", dp_start, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk("rst_dp_in", dp_in, '0);
    chk("rst_no_dp_start", ds_cnt, 0);
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    #1;
    chk("post_rst_s_ready", s_ready, 1'b1);

    // Table-driven frames
    for (int v = 0; v < 3; v++) begin
      d0 = ds_cnt;
      load(tbl[v].din, tbl[v].gap);
      for (int k = 0; k < 8; k++) begin
        e[k] = tbl[v].exp[perm(k)];
        ef[k*W +: W] = tbl[v].din[perm(k)];
      end
      chk("issue_dp_start", dp_start, 1'b1);
      chk("issue_s_ready", s_ready, 1'b0);
      chk("issue_busy", busy, 1'b1);
      chk("issue_dp_in", dp_in, ef);
      tick;
      chk("wait_dp_start_low", dp_start, 1'b0);
      b = 1;
      while (!m_valid && b < 50) begin
        chk("wait_dp_in_held", dp_in, ef);
        tick;
        b++;
      end
      chk("issue_to_drain_cycles", b, LAT + 1);
      drain(e, tbl[v].rdy);
      chk("dp_start_once", ds_cnt - d0, 1);
    end

    // Reset after 5 input samples, then a clean frame 9..16
    d0 = ds_cnt;
    s_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      s_data = W'(n + 1);
      tick;
    end
    s_valid = 1'b0;
    rst = 1'b1;
    tick;
    chk("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_s_ready", s_ready, 1'b1);
    repeat (6) tick;
    chk("midrst_no_dp_start", ds_cnt - d0, 0);
    for (int k = 0; k < 8; k++) e[k] = W'(9 + k);
    load(e, 0);
    for (int k = 0; k < 8; k++) e[k] = W'(9 + perm(k));
    drain(e, 4'b1111);
    chk("midrst_one_frame", ds_cnt - d0, 1);

    // Reset while waiting on the datapath drops the pending result
    for (int k = 0; k < 8; k++) e[k] = W'(16'h0C00 + k);
    load(e, 0);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("waitrst_s_ready", s_ready, 1'b1);
    b = 0;
    repeat (LAT + 4) begin
      if (m_valid) b++;
      tick;
    end
    chk("waitrst_no_output", b, 0);

    // s_valid held high across two back-to-back frames
    begin : cont
      logic [W-1:0] samp [16];
      logic [W:0]   outq [$];
      int ds_t [$];
      int mv_t [$];
      int lows [$];
      int k, lowrun;
      logic prev_mv;
      k = 0; lowrun = 0; prev_mv = 1'b0;
      for (int i = 0; i < 16; i++) samp[i] = W'(16'h0A00 + i);
      m_ready = 1'b1;
      for (int t = 0; t < 120 && outq.size() < 16; t++) begin
        s_valid = (k < 16);
        s_data  = samp[(k < 16) ? k : 0];
        if (dp_start) ds_t.push_back(t);
        if (m_valid && !prev_mv) mv_t.push_back(t);
        prev_mv = m_valid;
        if (!s_ready) lowrun++;
        else begin
          if (lowrun > 0) lows.push_back(lowrun);
          lowrun = 0;
        end
        if (s_valid && s_ready) k++;
        if (m_valid && m_ready) outq.push_back({m_last, m_data});
        tick;
      end
      s_valid = 1'b0;
      m_ready = 1'b0;
      chk("cont_dp_start_count", ds_t.size(), 2);
      chk("cont_drain_count", mv_t.size(), 2);
      for (int f = 0; f < 2; f++) begin
        if (ds_t.size() > f && mv_t.size() > f)
          chk($sformatf("cont_start_to_drain[%0d]", f), mv_t[f] - ds_t[f], LAT + 1);
      end
      chk("cont_ready_low_frame0", (lows.size() > 0) ? lows[0] : 0, 12);
      chk("cont_ready_low_frame1", lowrun, 12);
      chk("cont_out_count", outq.size(), 16);
      for (int i = 0; i < 16 && i < outq.size(); i++)
        chk($sformatf("cont_out[%0d]", i), outq[i],
            {((i % 8) == 7), samp[(i / 8) * 8 + perm(i % 8)]});
      chk("cont_end_s_ready", s_ready, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_seq_ctrl.md
FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, meaning sample width W = 2**N bits.
REQ-002 SHALL have parameter LAT, default 3, meaning datapath cycles from dp_start to valid dp_res; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port s_valid  input  1  input sample valid.
REQ-006 SHALL have port s_ready  output  1  controller accepts an input sample.
REQ-007 SHALL have port s_data  input  W  input sample.
REQ-008 SHALL have port dp_start  output  1  one-cycle frame-issue strobe to the FFT datapath.
REQ-009 SHALL have port dp_in  output  8*W  frame to the datapath, slot k at bits [k*W +: W].
REQ-010 SHALL have port dp_res  input  8*W  datapath result frame, same slot packing.
REQ-011 SHALL have port m_valid  output  1  output sample valid.
REQ-012 SHALL have port m_ready  input  1  downstream accepts output sample.
REQ-013 SHALL have port m_data  output  W  output sample.
REQ-014 SHALL have port m_last  output  1  marks slot 7 of the output frame.
REQ-015 SHALL have port busy  output  1  high in every state except LOAD.

Function
REQ-016 SHALL implement FSM states LOAD, ISSUE, WAIT, DRAIN; exactly one frame in flight.
REQ-017 LOAD: s_ready=1; each s_valid&s_ready writes s_data to slot idx, then idx increments 0..7.
REQ-018 On the handshake with idx=7, SHALL go to ISSUE next cycle and clear idx to 0.
REQ-019 ISSUE: dp_start=1 for exactly one cycle; next state WAIT; lat counter loads 0.
REQ-020 WAIT: lat counter increments each cycle; dp_res SHALL be captured into the result buffer on the cycle exactly LAT cycles after the dp_start cycle, then state DRAIN.
REQ-021 dp_in SHALL hold the loaded frame unchanged from ISSUE until the capture cycle inclusive.
REQ-022 DRAIN: m_valid=1, m_data=result slot idx, m_last=(idx==7); idx increments only on m_valid&m_ready.
REQ-023 m_data/m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-024 Handshake with m_last=1 SHALL return to LOAD with idx=0; s_ready rises the following cycle, never in the same cycle.
REQ-025 s_ready=0 and m_valid=0 outside LOAD and DRAIN respectively; s_data ignored outside LOAD.
REQ-026 No arithmetic on samples; data passes bit-exact; idx is 3 bits and wraps 7->0; lat counter 4 bits.

Reset
REQ-027 While rst=1: state=LOAD, idx=0, lat=0, s_ready=0, dp_start=0, m_valid=0, m_last=0, busy=0, m_data=0, dp_in=0, buffers cleared.
REQ-028 rst mid-frame (any state) SHALL discard partial input and pending results; first cycle after rst deasserts: s_ready=1.

Configuration
REQ-029 Macro FFT_SEQ_CTRL_BITREV_EN defined: input sample n written to slot bitrev3(n) (0,4,2,6,1,5,3,7); undefined: slot n.
REQ-030 Output order SHALL be natural slot order 0..7 in both builds.

Structure
REQ-031 Shared package fft_pkg SHALL hold FRAME_LEN=8, state enum, bitrev3 function, width helper W=2**N.
REQ-032 One sub-module fft_frame_buf SHALL implement an 8xW register buffer with write-enable/index and flat 8*W read port; instantiated twice (input and result).

Verification
REQ-033 Load 1..8 with s_valid held, stub datapath dp_res=dp_in delayed LAT=3 -> dp_start once, m_data 1..8, m_last on 8.
REQ-034 BITREV build, load 1..8, identity stub -> m_data order 1,5,3,7,2,6,4,8.
REQ-035 m_ready toggling 1,0,0,1 during DRAIN -> no sample lost/duplicated, m_data stable while stalled.
REQ-036 rst pulse after 5 input samples -> no dp_start; next 8 samples 9..16 yield output 9..16 only.
REQ-037 s_valid=1 continuously across two frames -> s_ready=0 from ISSUE until cycle after last output handshake; dp_start exactly 3 cycles apart from capture per frame with LAT=3.
